// File: rtl/single_pc_fetch_pkg.sv
// Shared types and constants for the single-outstanding-request fetch stage.
package single_pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR    = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/single_pc_nextsel.sv
// Next-PC select for a consumed instruction: jump beats branch beats sequential.
module single_pc_nextsel
  import single_pc_fetch_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  output logic [31:0] o_next_pc
);

  always_comb begin
    o_next_pc = align_word(i_pc_plus4);
    if (i_jump) begin
      o_next_pc = align_word(i_jump_target);
    end else if (i_branch_taken) begin
      o_next_pc = align_word(i_branch_target);
    end
  end

endmodule

// File: rtl/single_pc_fetch.sv
// Single-PC fetch stage: one outstanding imem request, one registered instruction
// slot, and redirect handling that never lets a stale fetch reach decode.
module single_pc_fetch
  import single_pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = DEFAULT_NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_flush,
  input  logic [31:0] i_flush_target,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: the imem read completes in any REQ cycle with i_imem_ack high;
  // decode takes o_instr in any cycle where o_instr_valid and i_instr_ready are both high.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         req_q, req_d;
  logic         flush_pending_q, flush_pending_d;
  logic [31:0]  flush_tgt_q, flush_tgt_d;
  logic [31:0]  next_pc;

  single_pc_nextsel u_nextsel (
    .i_pc_plus4      (i_pc_plus4),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .o_next_pc       (next_pc)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    instr_valid_d   = instr_valid_q;
    flush_pending_d = flush_pending_q;
    flush_tgt_d     = flush_tgt_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (i_flush) pc_d = align_word(i_flush_target);
      end
      ST_REQ: begin
        if (i_imem_ack) begin
          // A redirect seen while the read was in flight makes this data stale.
          if (flush_pending_q || i_flush) begin
            pc_d            = align_word(i_flush ? i_flush_target : flush_tgt_q);
            flush_pending_d = 1'b0;
          end else begin
            instr_d       = i_imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else if (i_flush) begin
          flush_tgt_d     = i_flush_target;
          flush_pending_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_flush) begin
          pc_d          = align_word(i_flush_target);
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end else if (i_instr_ready) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end
      end
      default: begin
        state_d       = ST_BOOT;
        instr_valid_d = 1'b0;
      end
    endcase
    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VECTOR;
      instr_q         <= NOP_INSTR;
      instr_valid_q   <= 1'b0;
      req_q           <= 1'b0;
      flush_pending_q <= 1'b0;
      flush_tgt_q     <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      instr_valid_q   <= instr_valid_d;
      req_q           <= req_d;
      flush_pending_q <= flush_pending_d;
      flush_tgt_q     <= flush_tgt_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_instr       = instr_q;
  assign o_instr_valid = instr_valid_q;
  assign o_imem_req    = req_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_single_pc_fetch.sv
// Directed and randomized bench for single_pc_fetch against a transaction-level model.
module tb_single_pc_fetch;
  import single_pc_fetch_pkg::*;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic [31:0] o_pc;
  logic [31:0] i_pc_plus4;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_flush;
  logic [31:0] i_flush_target;
  logic        o_imem_req;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [1:0]  o_dbg_state;

  single_pc_fetch #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .o_pc            (o_pc),
    .i_pc_plus4      (i_pc_plus4),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_flush         (i_flush),
    .i_flush_target  (i_flush_target),
    .o_imem_req      (o_imem_req),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_instr         (o_instr),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (i_instr_ready),
    .o_dbg_state     (o_dbg_state)
  );

  // Clock/reset block; the external +4 adder lives in the environment.
  always #5 i_clk = ~i_clk;
  assign i_pc_plus4 = o_pc + 32'd4;

  int total = 0;
  int bad   = 0;

  // Scoreboard: instruction words accepted from memory and owed to decode.
  logic [31:0] exp_q[$];

  // Model: booting, holding an instruction, or otherwise requesting.
  bit          m_boot;
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_redir;
  logic [31:0] m_redir_tgt;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit req_exp;
    req_exp = !m_boot && !m_valid;
    chk("pc", o_pc, m_pc);
    chk("imem_req", {31'b0, o_imem_req}, {31'b0, req_exp});
    chk("instr_valid", {31'b0, o_instr_valid}, {31'b0, m_valid});
    chk("dbg_state_req", {31'b0, o_dbg_state == ST_REQ}, {31'b0, req_exp});
    if (m_valid && exp_q.size() > 0) chk("instr", o_instr, exp_q[0]);
  endtask

  task automatic model_reset();
    m_boot      = 1'b1;
    m_valid     = 1'b0;
    m_pc        = RV;
    m_redir     = 1'b0;
    m_redir_tgt = 32'h0;
    exp_q.delete();
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] consumed_next;
    logic [31:0] popped;
    consumed_next = i_jump ? i_jump_target : (i_branch_taken ? i_branch_target : m_pc + 32'd4);
    if (m_boot) begin
      m_boot = 1'b0;
      if (i_flush) m_pc = word(i_flush_target);
    end else if (m_valid) begin
      if (i_flush) begin
        popped  = exp_q.pop_front();
        m_pc    = word(i_flush_target);
        m_valid = 1'b0;
      end else if (i_instr_ready) begin
        popped = exp_q.pop_front();
        chk("handoff_instr", o_instr, popped);
        m_pc    = word(consumed_next);
        m_valid = 1'b0;
      end
    end else if (i_imem_ack) begin
      if (i_flush || m_redir) begin
        m_pc    = word(i_flush ? i_flush_target : m_redir_tgt);
        m_redir = 1'b0;
      end else begin
        exp_q.push_back(i_imem_rdata);
        m_valid = 1'b1;
      end
    end else if (i_flush) begin
      m_redir     = 1'b1;
      m_redir_tgt = i_flush_target;
    end
  endtask

  // Driver tasks.
  task automatic idle_inputs();
    i_branch_taken  = 1'b0;
    i_branch_target = 32'h0;
    i_jump          = 1'b0;
    i_jump_target   = 32'h0;
    i_flush         = 1'b0;
    i_flush_target  = 32'h0;
    i_imem_ack      = 1'b0;
    i_imem_rdata    = 32'h0;
    i_instr_ready   = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("reset_instr", o_instr, NOP);
    repeat (cycles) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset(2);

    // Back-to-back fetches with immediate ack and ready decode.
    i_imem_ack = 1'b1; i_instr_ready = 1'b1; i_imem_rdata = $urandom;
    tick(); chk("c1_req", {31'b0, o_imem_req}, 32'd1); chk("c1_pc", o_pc, 32'h0);
    i_imem_rdata = $urandom;
    tick(); chk("c2_valid", {31'b0, o_instr_valid}, 32'd1);
    tick(); chk("c3_pc", o_pc, 32'h4);
    i_imem_rdata = $urandom;
    tick(); chk("c4_valid", {31'b0, o_instr_valid}, 32'd1);
    tick(); chk("c5_pc", o_pc, 32'h8);
    i_imem_rdata = $urandom;
    tick(); chk("c6_valid", {31'b0, o_instr_valid}, 32'd1);

    // Decode stall in HOLD.
    i_instr_ready = 1'b0;
    repeat (3) begin
      tick(); chk("stall_pc", o_pc, 32'h8); chk("stall_req", {31'b0, o_imem_req}, 32'd0);
    end
    i_instr_ready = 1'b1;
    tick(); chk("after_stall_pc", o_pc, 32'hC); chk("after_stall_req", {31'b0, o_imem_req}, 32'd1);

    // Jump beats branch.
    i_imem_rdata = $urandom; tick();
    i_jump = 1'b1; i_jump_target = 32'h100; i_branch_taken = 1'b1; i_branch_target = 32'h200;
    tick(); chk("jump_pc", o_pc, 32'h100);
    i_jump = 1'b0; i_branch_taken = 1'b0;

    // Flush while a read is outstanding; the late data must be dropped.
    i_imem_ack = 1'b0; i_flush = 1'b1; i_flush_target = 32'h80;
    tick(); chk("pend_pc", o_pc, 32'h100);
    i_flush = 1'b0;
    tick();
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    tick(); chk("drop_valid", {31'b0, o_instr_valid}, 32'd0); chk("drop_pc", o_pc, 32'h80);
    chk("drop_req", {31'b0, o_imem_req}, 32'd1);
    i_imem_rdata = 32'h1234_5678; tick();

    // Misaligned branch target and address wrap.
    i_branch_taken = 1'b1; i_branch_target = 32'h0000_0013;
    tick(); chk("align_pc", o_pc, 32'h10);
    tick();
    i_branch_target = 32'hFFFF_FFFC;
    tick(); chk("top_pc", o_pc, 32'hFFFF_FFFC);
    i_branch_taken = 1'b0;
    tick();
    tick(); chk("wrap_pc", o_pc, 32'h0);

    // Second flush overwrites the stored target.
    i_imem_ack = 1'b0; i_flush = 1'b1; i_flush_target = 32'h40;
    tick();
    i_flush_target = 32'h61;
    tick();
    i_flush = 1'b0; i_imem_ack = 1'b1;
    tick(); chk("overwrite_pc", o_pc, 32'h60);
    tick();

    // Flush in HOLD overrides a simultaneous jump handshake.
    i_flush = 1'b1; i_flush_target = 32'h200; i_jump = 1'b1; i_jump_target = 32'h300;
    tick(); chk("flush_hold_pc", o_pc, 32'h200); chk("flush_hold_valid", {31'b0, o_instr_valid}, 32'd0);
    i_flush = 1'b0; i_jump = 1'b0;

    // Reset mid-request with a late ack.
    i_imem_ack = 1'b0; tick(); tick();
    i_imem_ack = 1'b1;
    do_reset(1);
    tick(); chk("late_ack_valid", {31'b0, o_instr_valid}, 32'd0); chk("late_ack_pc", o_pc, RV);
    tick(); chk("resume_valid", {31'b0, o_instr_valid}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      i_instr_ready   = ($urandom_range(0, 2) != 0);
      i_imem_ack      = ($urandom_range(0, 3) != 0);
      i_imem_rdata    = $urandom;
      i_flush         = ($urandom_range(0, 11) == 0);
      i_flush_target  = $urandom;
      i_jump          = ($urandom_range(0, 3) == 0);
      i_jump_target   = $urandom;
      i_branch_taken  = ($urandom_range(0, 2) == 0);
      i_branch_target = $urandom;
      if ($urandom_range(0, 249) == 0) do_reset($urandom_range(1, 3));
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
